// File: rtl/tmds_enc_pkg.sv
// Shared symbol tables, mode encoding and helpers for the multi-lane TMDS encoder.
package tmds_enc_pkg;

  typedef enum logic [2:0] {
    M_CTL = 3'd0,
    M_VID = 3'd1,
    M_VGB = 3'd2,
    M_DGB = 3'd3,
    M_DI  = 3'd4
  } mode_t;

  localparam logic [9:0] ENC_RST_SYMBOL = 10'd0;

  // Indexed by {c1,c0}
  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };

  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  localparam logic [9:0] VGB_CODE_0 = 10'b1011001100;
  localparam logic [9:0] VGB_CODE_1 = 10'b0100110011;
  localparam logic [9:0] DGB_CODE   = 10'b0100110011;

  function automatic logic [9:0] terc4(input logic [3:0] nib);
    return TERC4_CODE[nib];
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 builds q_m and the non-video symbol, stage 2 counts q_m ones,
// stage 3 picks the DC-balanced symbol and tracks running disparity. HDMI codes need TMDS_ENC_TERC4_EN.
module tmds_lane_enc
  import tmds_enc_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  mode_t      mode,
  input  mode_t      mode_s2,
  input  logic [1:0] ctl,
  input  logic [7:0] pix,
  input  logic [3:0] aux,
  output logic [9:0] encode_out
);

  logic [3:0]        n1_pix;
  logic              use_xnor;
  logic [8:0]        q_m_next;
  logic [9:0]        alt_next;
  logic [8:0]        q_m_s1_reg;
  logic [9:0]        alt_s1_reg;

  logic [3:0]        n1_q;
  logic signed [4:0] diff_next;
  logic signed [4:0] ndiff_next;
  logic [8:0]        q_m_s2_reg;
  logic [9:0]        alt_s2_reg;
  logic signed [4:0] diff_s2_reg;
  logic signed [4:0] ndiff_s2_reg;
  logic              gt_s2_reg;
  logic              lt_s2_reg;
  logic              eq_s2_reg;

  logic [9:0]        sym_next;
  logic signed [4:0] cnt_next;
  logic signed [4:0] cnt_reg;

  always_comb begin
    n1_pix      = ones8(pix);
    use_xnor    = (n1_pix > 4'd4) || ((n1_pix == 4'd4) && !pix[0]);
    q_m_next    = '0;
    q_m_next[0] = pix[0];
    for (int i = 1; i < 8; i++) begin
      q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ pix[i]) : (q_m_next[i-1] ^ pix[i]);
    end
    q_m_next[8] = ~use_xnor;
  end

  // Non-video symbol is resolved up front and simply rides the pipeline.
  always_comb begin
    alt_next = CTRL_CODE[ctl];
`ifdef TMDS_ENC_TERC4_EN
    case (mode)
      M_VGB:   alt_next = (LANE == 1) ? VGB_CODE_1 : VGB_CODE_0;
      M_DGB:   alt_next = (LANE == 0) ? terc4(aux) : DGB_CODE;
      M_DI:    alt_next = terc4(aux);
      default: alt_next = CTRL_CODE[ctl];
    endcase
`endif
  end

`ifndef TMDS_ENC_TERC4_EN
  localparam int lane_unused = LANE;
  logic unused_dvi;
  assign unused_dvi = ^{aux, mode};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m_s1_reg <= '0;
      alt_s1_reg <= ENC_RST_SYMBOL;
    end else begin
      q_m_s1_reg <= q_m_next;
      alt_s1_reg <= alt_next;
    end
  end

  always_comb begin
    n1_q       = ones8(q_m_s1_reg[7:0]);
    diff_next  = {n1_q, 1'b0} - 5'd8;
    ndiff_next = 5'd8 - {n1_q, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m_s2_reg   <= '0;
      alt_s2_reg   <= ENC_RST_SYMBOL;
      diff_s2_reg  <= '0;
      ndiff_s2_reg <= '0;
      gt_s2_reg    <= 1'b0;
      lt_s2_reg    <= 1'b0;
      eq_s2_reg    <= 1'b0;
    end else begin
      q_m_s2_reg   <= q_m_s1_reg;
      alt_s2_reg   <= alt_s1_reg;
      diff_s2_reg  <= diff_next;
      ndiff_s2_reg <= ndiff_next;
      gt_s2_reg    <= (n1_q > 4'd4);
      lt_s2_reg    <= (n1_q < 4'd4);
      eq_s2_reg    <= (n1_q == 4'd4);
    end
  end

  // Disparity stays in [-8,+8], so 5-bit modular arithmetic never wraps.
  always_comb begin
    sym_next = alt_s2_reg;
    cnt_next = '0;
    if (mode_s2 == M_VID) begin
      if ((cnt_reg == 5'sd0) || eq_s2_reg) begin
        sym_next = {~q_m_s2_reg[8], q_m_s2_reg[8],
                    q_m_s2_reg[8] ? q_m_s2_reg[7:0] : ~q_m_s2_reg[7:0]};
        cnt_next = cnt_reg + (q_m_s2_reg[8] ? diff_s2_reg : ndiff_s2_reg);
      end else if (((cnt_reg > 5'sd0) && gt_s2_reg) || ((cnt_reg < 5'sd0) && lt_s2_reg)) begin
        sym_next = {1'b1, q_m_s2_reg[8], ~q_m_s2_reg[7:0]};
        cnt_next = cnt_reg + {3'b000, q_m_s2_reg[8], 1'b0} + ndiff_s2_reg;
      end else begin
        sym_next = {1'b0, q_m_s2_reg[8], q_m_s2_reg[7:0]};
        cnt_next = cnt_reg - {3'b000, ~q_m_s2_reg[8], 1'b0} + diff_s2_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encode_out <= ENC_RST_SYMBOL;
      cnt_reg    <= '0;
    end else begin
      encode_out <= sym_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-lane TMDS encoder top: decodes the period type once, pipelines it, and fans out to lanes.
// TERC4 data islands and guard bands exist only when TMDS_ENC_TERC4_EN is defined.
module tmds_encoder_mc
  import tmds_enc_pkg::*;
#(
  parameter int  CH_N      = 3,
  parameter real SIM_DELAY = 1.0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hs,
  input  logic                 vs,
  input  logic                 de,
  input  logic                 vgb,
  input  logic                 dgb,
  input  logic                 di,
  input  logic [2*CH_N-1:0]    ctl,
  input  logic [8*CH_N-1:0]    pix,
  input  logic [4*CH_N-1:0]    aux,
  output logic [10*CH_N-1:0]   encode_out
);

  localparam real sim_delay_unused = SIM_DELAY;

  mode_t mode_next;
  mode_t mode_s1_reg;
  mode_t mode_s2_reg;

  always_comb begin
    mode_next = M_CTL;
`ifdef TMDS_ENC_TERC4_EN
    if (de)       mode_next = M_VID;
    else if (vgb) mode_next = M_VGB;
    else if (dgb) mode_next = M_DGB;
    else if (di)  mode_next = M_DI;
`else
    if (de)       mode_next = M_VID;
`endif
  end

`ifndef TMDS_ENC_TERC4_EN
  logic unused_hdmi;
  assign unused_hdmi = ^{vgb, dgb, di};
`endif

  // Lane 0 takes sync from hs/vs, so its own ctl/aux low bits are never read.
  logic unused_lane0;
  assign unused_lane0 = ^{ctl[1:0], aux[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_reg <= M_CTL;
      mode_s2_reg <= M_CTL;
    end else begin
      mode_s1_reg <= mode_next;
      mode_s2_reg <= mode_s1_reg;
    end
  end

  for (genvar gi = 0; gi < CH_N; gi++) begin : g_lane
    logic [1:0] lane_ctl;
    logic [3:0] lane_aux;

    if (gi == 0) begin : g_sync
      assign lane_ctl = {vs, hs};
      assign lane_aux = {(mode_next == M_DGB) ? 2'b11 : aux[3:2], vs, hs};
    end else begin : g_plain
      assign lane_ctl = ctl[2*gi +: 2];
      assign lane_aux = aux[4*gi +: 4];
    end

    tmds_lane_enc #(
      .LANE(gi)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode_next),
      .mode_s2   (mode_s2_reg),
      .ctl       (lane_ctl),
      .pix       (pix[8*gi +: 8]),
      .aux       (lane_aux),
      .encode_out(encode_out[10*gi +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Self-checking bench for tmds_encoder_mc: directed vector table, hand sequences and a
// randomized scoreboard against a disparity-counting reference model.
module tb_tmds_encoder_mc;

  localparam int CH = 4;
  localparam int W  = 10 * CH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            hs, vs, de, vgb, dgb, di;
  logic [2*CH-1:0] ctl;
  logic [8*CH-1:0] pix;
  logic [4*CH-1:0] aux;
  logic [W-1:0]    encode_out;

  tmds_encoder_mc #(
    .CH_N(CH),
    .SIM_DELAY(1.0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs(hs), .vs(vs), .de(de), .vgb(vgb), .dgb(dgb), .di(di),
    .ctl(ctl), .pix(pix), .aux(aux), .encode_out(encode_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_cnt    [CH];
  int obs_disp [CH];

  logic [9:0] ctl_tab [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  logic [9:0] t4_tab  [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                               10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};

  typedef struct {
    logic [W-1:0]    sym;
    logic            vid;
    logic [8*CH-1:0] pix;
    logic            has_dir;
    logic [W-1:0]    dir_sym;
    int              tag;
  } exp_t;
  exp_t exp_q [$];

  typedef struct {
    logic            hs, vs, de, vgb, dgb, di;
    logic [2*CH-1:0] ctl;
    logic [8*CH-1:0] pix;
    logic [4*CH-1:0] aux;
    logic [W-1:0]    exp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", what, act, req);
  endtask

  // Spec-level 8b/10b: choose inversion from signs, track disparity as ones minus zeros.
  function automatic logic [9:0] model_video(input int k, input logic [7:0] d);
    int n1, dd;
    logic use_xnor, inv;
    logic [8:0] qm;
    logic [9:0] s;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    dd = 2 * $countones(qm[7:0]) - 8;
    if (m_cnt[k] == 0 || dd == 0) inv = ~qm[8];
    else inv = ((m_cnt[k] > 0) == (dd > 0));
    s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    m_cnt[k] += 2 * $countones(s) - 10;
    return s;
  endfunction

  function automatic logic [W-1:0] model_step();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      logic [9:0] s;
      logic [1:0] c;
      logic [3:0] nib;
      c   = (k == 0) ? {vs, hs} : ctl[2*k +: 2];
      nib = (k == 0) ? {aux[3:2], vs, hs} : aux[4*k +: 4];
      if (de) s = model_video(k, pix[8*k +: 8]);
      else begin
        m_cnt[k] = 0;
        s = ctl_tab[c];
`ifdef TMDS_ENC_TERC4_EN
        if (vgb)      s = (k == 1) ? 10'h133 : 10'h2CC;
        else if (dgb) s = (k == 0) ? t4_tab[{2'b11, vs, hs}] : 10'h133;
        else if (di)  s = t4_tab[nib];
`endif
      end
      r[10*k +: 10] = s;
    end
    return r;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, b;
    d = s[9] ? ~s[7:0] : s[7:0];
    b[0] = d[0];
    for (int i = 1; i < 8; i++) b[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return b;
  endfunction

  // Called at a negedge with inputs already driven; checks the symbol due now.
  task automatic step(input int tag, input logic has_dir, input logic [W-1:0] dsym);
    exp_t e;
    e.sym = model_step(); e.vid = de; e.pix = pix;
    e.has_dir = has_dir; e.dir_sym = dsym; e.tag = tag;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check($sformatf("model t%0d", e.tag), encode_out, e.sym);
      if (e.has_dir) check($sformatf("directed t%0d", e.tag), encode_out, e.dir_sym);
      for (int k = 0; k < CH; k++) begin
        logic [9:0] s;
        s = encode_out[10*k +: 10];
        if (e.vid) begin
          obs_disp[k] += 2 * $countones(s) - 10;
          check($sformatf("decode t%0d lane%0d", e.tag, k), decode(s), e.pix[8*k +: 8]);
          check($sformatf("disp_bound lane%0d disp=%0d", k, obs_disp[k]),
                (obs_disp[k] <= 8 && obs_disp[k] >= -8), 1);
        end else obs_disp[k] = 0;
      end
    end
  endtask

  task automatic set_idle();
    hs = 0; vs = 0; de = 0; vgb = 0; dgb = 0; di = 0; ctl = '0; pix = '0; aux = '0;
  endtask

  task automatic rand_blank();
    logic [31:0] r;
    r = $urandom;
    de = 0; hs = r[0]; vs = r[1];
    vgb = (r[4:2] == 3'd0); dgb = (r[7:5] == 3'd0); di = (r[9:8] != 2'd0);
    ctl = r[10 +: 2*CH]; aux = r[18 +: 4*CH]; pix = $urandom;
  endtask

  task automatic rand_vid();
    logic [31:0] r;
    r = $urandom;
    de = 1; hs = r[0]; vs = r[1]; vgb = r[2]; dgb = r[3]; di = r[4];
    ctl = r[8 +: 2*CH]; aux = r[16 +: 4*CH];
    case (r[31:29])
      3'd0:    pix = '0;
      3'd1:    pix = '1;
      default: pix = $urandom;
    endcase
  endtask

  task automatic do_reset(input int cycles);
    exp_t z;
    rst_n = 1'b0;
    exp_q.delete();
    for (int k = 0; k < CH; k++) begin m_cnt[k] = 0; obs_disp[k] = 0; end
    repeat (cycles) begin
      rand_vid();
      #1 check("reset_out", encode_out, '0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    z.sym = '0; z.vid = 0; z.pix = '0; z.has_dir = 1; z.dir_sym = '0; z.tag = -1;
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
`ifdef TMDS_ENC_TERC4_EN
    vecs[1] = '{1, 0, 0, 1, 0, 0, 8'hE3, '0, '0, {10'h2CC, 10'h2CC, 10'h133, 10'h2CC}};
    vecs[3] = '{0, 1, 0, 0, 1, 0, 8'hE3, '0, '0, {10'h133, 10'h133, 10'h133, 10'h163}};
    vecs[4] = '{0, 0, 0, 0, 0, 1, 8'hE3, '0, 16'h8F04, {10'h2CC, 10'h2C3, 10'h29C, 10'h171}};
    vecs[5] = '{1, 1, 0, 0, 1, 1, 8'hE3, '0, 16'h8F04, {10'h133, 10'h133, 10'h133, 10'h2C3}};
`else
    vecs[1] = '{1, 0, 0, 1, 0, 0, 8'hE3, '0, '0, {10'h2AB, 10'h154, 10'h354, 10'h0AB}};
    vecs[3] = '{0, 1, 0, 0, 1, 0, 8'hE3, '0, '0, {10'h2AB, 10'h154, 10'h354, 10'h154}};
    vecs[4] = '{0, 0, 0, 0, 0, 1, 8'hE3, '0, 16'h8F04, {10'h2AB, 10'h154, 10'h354, 10'h354}};
    vecs[5] = '{1, 1, 0, 0, 1, 1, 8'hE3, '0, 16'h8F04, {10'h2AB, 10'h154, 10'h354, 10'h2AB}};
`endif
    vecs[0] = '{1, 0, 0, 0, 0, 0, 8'hE3, '0, '0, {10'h2AB, 10'h154, 10'h354, 10'h0AB}};
    vecs[2] = '{0, 0, 1, 1, 0, 0, 8'hE3, '0, '0, {CH{10'h100}}};
    vecs[6] = '{0, 1, 0, 0, 0, 0, 8'h74, '0, '0, {10'h0AB, 10'h2AB, 10'h0AB, 10'h154}};

    set_idle();
    @(negedge clk);
    do_reset(4);

    // First vector right after reset release also proves the 3-clock latency.
    for (int i = 0; i < 7; i++) begin
      hs = vecs[i].hs; vs = vecs[i].vs; de = vecs[i].de; vgb = vecs[i].vgb;
      dgb = vecs[i].dgb; di = vecs[i].di; ctl = vecs[i].ctl; pix = vecs[i].pix; aux = vecs[i].aux;
      step(i, 1, vecs[i].exp);
    end

    // Disparity from zero, then restart after a blanking cycle.
    set_idle(); step(100, 0, '0);
    de = 1; pix = '0; step(101, 1, {CH{10'h100}});
    step(102, 1, {CH{10'h3FF}});
    set_idle(); hs = 1; step(103, 0, '0);
    de = 1; pix = '0; step(104, 1, {CH{10'h100}});
    step(105, 1, {CH{10'h3FF}});
    set_idle(); step(106, 0, '0);

    for (int line = 0; line < 50; line++) begin
      int act_len, blank_len;
      act_len   = $urandom_range(200, 20);
      blank_len = $urandom_range(16, 4);
      for (int p = 0; p < act_len; p++) begin
        rand_vid();
        step(1000 + line, 0, '0);
      end
      if (line == 25) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_out", encode_out, '0);
        @(negedge clk);
        do_reset(2);
      end
      for (int b = 0; b < blank_len; b++) begin
        rand_blank();
        step(2000 + line, 0, '0);
      end
    end

    set_idle();
    repeat (3) step(3000, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
